// File: rtl/fsm_prga_decryptor.sv
// RC4 PRGA: re-swaps the shuffled S-box, XORs keystream with ciphertext ROM.
// Optional PRGA_ASCII_CHECK_EN aborts to FAIL on a non [a-z ] plaintext byte.
module fsm_prga_decryptor #(
   parameter int MSG_LEN = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] s_q,
   input  logic [7:0] enc_q,
   output logic [7:0] s_addr,
   output logic [7:0] s_data,
   output logic       s_wren,
   output logic [7:0] enc_addr,
   output logic [7:0] dec_addr,
   output logic [7:0] dec_data,
   output logic       dec_wren,
   output logic       busy,
   output logic       done,
   output logic       fail
);

   localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

   typedef enum logic [3:0] {
      IDLE, INC_I, RD_SI, WT_SI, CAP_SI, RD_SJ, WT_SJ, CAP_SJ,
      WR_SI, WR_SJ, WT_F, CAP_F, WR_DEC, DONE, FAIL
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] i_q, i_d;
   logic [7:0] j_q, j_d;
   logic [7:0] k_q, k_d;
   logic [7:0] si_q, si_d;
   logic [7:0] sj_q, sj_d;
   logic [7:0] s_addr_q, s_addr_d;
   logic [7:0] s_data_q, s_data_d;
   logic [7:0] enc_addr_q, enc_addr_d;
   logic [7:0] dec_addr_q, dec_addr_d;
   logic [7:0] dec_data_q, dec_data_d;
   logic [7:0] plain;

   assign plain = s_q ^ enc_q;

`ifdef PRGA_ASCII_CHECK_EN
   logic asc_ok;
   assign asc_ok = (plain == 8'h20) ||
                   ((plain >= 8'h61) && (plain <= 8'h7A));
`endif

   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      k_d        = k_q;
      si_d       = si_q;
      sj_d       = sj_q;
      s_addr_d   = s_addr_q;
      s_data_d   = s_data_q;
      enc_addr_d = enc_addr_q;
      dec_addr_d = dec_addr_q;
      dec_data_d = dec_data_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               i_d     = 8'd0;
               j_d     = 8'd0;
               k_d     = 8'd0;
               state_d = INC_I;
            end
         end
         INC_I: begin
            i_d     = i_q + 8'd1;
            state_d = RD_SI;
         end
         RD_SI: begin
            s_addr_d = i_q;
            state_d  = WT_SI;
         end
         WT_SI: state_d = CAP_SI;
         CAP_SI: begin
            si_d    = s_q;
            j_d     = j_q + s_q;
            state_d = RD_SJ;
         end
         RD_SJ: begin
            s_addr_d = j_q;
            state_d  = WT_SJ;
         end
         WT_SJ: state_d = CAP_SJ;
         CAP_SJ: begin
            sj_d     = s_q;
            s_addr_d = i_q;
            s_data_d = s_q;
            state_d  = WR_SI;
         end
         WR_SI: begin
            s_addr_d = j_q;
            s_data_d = si_q;
            state_d  = WR_SJ;
         end
         // Swap writes land before this read, so S[si+sj] sees the new S.
         WR_SJ: begin
            s_addr_d   = si_q + sj_q;
            enc_addr_d = k_q;
            state_d    = WT_F;
         end
         WT_F: state_d = CAP_F;
         CAP_F: begin
`ifdef PRGA_ASCII_CHECK_EN
            if (!asc_ok) begin
               state_d = FAIL;
            end else begin
               dec_data_d = plain;
               dec_addr_d = k_q;
               state_d    = WR_DEC;
            end
`else
            dec_data_d = plain;
            dec_addr_d = k_q;
            state_d    = WR_DEC;
`endif
         end
         WR_DEC: begin
            if (k_q == K_LAST) begin
               state_d = DONE;
            end else begin
               k_d     = k_q + 8'd1;
               state_d = INC_I;
            end
         end
         DONE, FAIL: begin
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         i_q        <= 8'd0;
         j_q        <= 8'd0;
         k_q        <= 8'd0;
         si_q       <= 8'd0;
         sj_q       <= 8'd0;
         s_addr_q   <= 8'd0;
         s_data_q   <= 8'd0;
         enc_addr_q <= 8'd0;
         dec_addr_q <= 8'd0;
         dec_data_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         j_q        <= j_d;
         k_q        <= k_d;
         si_q       <= si_d;
         sj_q       <= sj_d;
         s_addr_q   <= s_addr_d;
         s_data_q   <= s_data_d;
         enc_addr_q <= enc_addr_d;
         dec_addr_q <= dec_addr_d;
         dec_data_q <= dec_data_d;
      end
   end

   assign s_addr   = s_addr_q;
   assign s_data   = s_data_q;
   assign enc_addr = enc_addr_q;
   assign dec_addr = dec_addr_q;
   assign dec_data = dec_data_q;
   assign s_wren   = (state_q == WR_SI) || (state_q == WR_SJ);
   assign dec_wren = (state_q == WR_DEC);
   assign done     = (state_q == DONE);
   assign busy     = !((state_q == IDLE) || (state_q == DONE) ||
                       (state_q == FAIL));
`ifdef PRGA_ASCII_CHECK_EN
   assign fail     = (state_q == FAIL);
`else
   assign fail     = 1'b0;
`endif

endmodule
